rx_data_fifo: RTL and testbench
===============================

RX_DATA_FIFO -- requirements
Module: rx_data_fifo

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of each data word.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; a power of 2, at least 2. ADDR_W = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sync_bus, input, BUS_WIDTH bits: data word from the data synchronizer.
REQ-006 SHALL have port enable_pulse, input, 1 bit: one-cycle strobe marking sync_bus valid.
REQ-007 SHALL have port rd_ready, input, 1 bit: the consumer accepts the head word.
REQ-008 SHALL have port clr_ovf, input, 1 bit: clears the overflow status.
REQ-009 SHALL have port rd_data, output, BUS_WIDTH bits: head word.
REQ-010 SHALL have port rd_valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-012 SHALL have port count, output, ADDR_W+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-014 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped words.

Function
REQ-015 Push condition: enable_pulse=1 and (full=0 or pop in the same cycle). Sync_bus is then written at wr_ptr and wr_ptr increments.
REQ-016 Pop condition: rd_valid=1 and rd_ready=1. Rd_ptr increments.
REQ-017 Pointers SHALL be ADDR_W bits and wrap from DEPTH-1 to 0.
REQ-018 Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 Reads SHALL be first-word-fall-through: rd_data = mem[rd_ptr] while rd_valid=1, and all-zero while rd_valid=0.
REQ-020 Latency SHALL be 1 cycle: rd_valid asserts in the cycle after the push into an empty FIFO.
REQ-021 Empty FIFO with enable_pulse and rd_ready both high: the push occurs, no pop occurs, and count becomes 1.
REQ-022 Full FIFO with pop and enable_pulse in the same cycle: both occur, count stays DEPTH, and nothing is dropped.
REQ-023 Drop condition: enable_pulse=1, full=1, no pop. The word is discarded and memory/pointers are unchanged.
REQ-024 On a drop: overflow is set to 1; drop_cnt increments and saturates at 255.
REQ-025 clr_ovf=1 SHALL zero overflow and drop_cnt on the next edge. A drop in the same cycle overrides: overflow=1, drop_cnt=1.
REQ-026 Pop on an empty FIFO SHALL be ignored, with no underflow.
REQ-027 Full and rd_valid SHALL be decoded from registered count, with no combinational path from inputs.

Reset
REQ-028 rst=1 at a clk edge SHALL zero wr_ptr, rd_ptr, count, overflow and drop_cnt. Result: rd_valid=0, full=0, rd_data=0.
REQ-029 Memory contents SHALL not need reset; old words SHALL never become visible after reset.
REQ-030 Reset mid-operation SHALL discard all queued words. A coincident enable_pulse during rst SHALL be ignored.
REQ-031 The first enable_pulse after rst deasserts SHALL be accepted normally.

Verification
REQ-032 Single word: after reset, pulse with sync_bus=0xA5, rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, count=1. Then rd_ready=1 for 1 cycle -> rd_valid=0, rd_data=0x00.
REQ-033 Fill/wrap: push 0x01..0x08 (full=1, count=8), pop 3, push 0x09..0x0B -> pop order 0x04..0x0B, with no drop.
REQ-034 Overflow: fill 8, then 300 further pulses with rd_ready=0 -> overflow=1, drop_cnt=255, head still 0x01. Then clr_ovf=1 -> both 0.
REQ-035 Simultaneous full push+pop: full with head 0x01, pulse 0x99 with rd_ready=1 -> count=8, overflow=0, 0x99 read last.
REQ-036 Reset mid-stream: with 5 words queued, assert rst together with enable_pulse -> count=0, rd_valid=0. The next pulse of 0x3C appears as head.
REQ-037 Clear/drop collision: full FIFO, drop_cnt=4, clr_ovf and enable_pulse both high with rd_ready=0 -> overflow=1, drop_cnt=1.

Source files
------------

// File: rtl/rx_data_fifo.sv
// rx_data_fifo: receive-side FIFO for words from the data synchronizer.
// First-word-fall-through read port. Occupancy is kept in a registered
// counter, so full/rd_valid have no combinational path from inputs.
// Words arriving while full (with no simultaneous pop) are dropped, which
// sets a sticky overflow flag and bumps a saturating 8-bit drop counter.
module rx_data_fifo #(
  parameter  int BUS_WIDTH = 8,
  parameter  int DEPTH     = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] sync_bus,
  input  logic                 enable_pulse,
  input  logic                 rd_ready,
  input  logic                 clr_ovf,
  output logic [BUS_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [ADDR_W:0]      r_count;
  logic                 r_overflow;
  logic [7:0]           r_drop_cnt;

  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status decode from the registered count only.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_valid = (r_count != '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a word alongside a pop. A pop on an empty FIFO is never qualified.
  assign w_pop  = w_valid & rd_ready;
  assign w_push = enable_pulse & (~w_full | w_pop);
  assign w_drop = enable_pulse & w_full & ~w_pop;

  // Storage write. Reset is excluded so a pulse coincident with rst is ignored.
  // NOTE: the memory array is deliberately not reset; stale words can never
  // surface because rd_data is gated by rd_valid and count restarts at zero.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= sync_bus;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (ADDR_W + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (ADDR_W + 1)'(1);
    end
  end

  // Overflow status: a drop wins over a coincident clear, restarting at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)                  r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign rd_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign rd_valid = w_valid;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_rx_data_fifo.sv
// Self-checking bench for rx_data_fifo (BUS_WIDTH=8, DEPTH=8).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
// A queue holds the words expected at the head, in order.
module tb_rx_data_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] sync_bus;
  logic       enable_pulse;
  logic       rd_ready;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_word;

  rx_data_fifo #(.BUS_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .sync_bus(sync_bus), .enable_pulse(enable_pulse),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; returns 1ns after the edge with inputs idle.
  task automatic drive(input logic en, input logic [7:0] d,
                       input logic rdy, input logic clr);
    enable_pulse = en;
    sync_bus     = d;
    rd_ready     = rdy;
    clr_ovf      = clr;
    @(posedge clk);
    #1;
    enable_pulse = 1'b0;
    rd_ready     = 1'b0;
    clr_ovf      = 1'b0;
    sync_bus     = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rd_valid, full, count, overflow, drop_cnt, rd_data} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b full=%0b count=%0d ovf=%0b drop=%0d data=%h required all 0",
               rd_valid, full, count, overflow, drop_cnt, rd_data);
    end
  endtask

  task automatic test_single_word();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    sb.push_back(8'hA5);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== sb[0] || count !== 4'(sb.size())) begin
      n_fail++;
      $display("FAIL single_push: valid=%0b data=%h count=%0d required 1 %h %0d",
               rd_valid, rd_data, count, sb[0], sb.size());
    end
    void'(sb.pop_front());
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%0b data=%h count=%0d required 0 00 0",
               rd_valid, rd_data, count);
    end
  endtask

  task automatic test_empty_edges();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop: valid=%0b count=%0d full=%0b required 0 0 0",
               rd_valid, count, full);
    end
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    sb.push_back(8'h5A);
    n_checks++;
    if (rd_valid !== 1'b1 || count !== 4'd1 || rd_data !== sb[0]) begin
      n_fail++;
      $display("FAIL empty_push_pop: valid=%0b count=%0d data=%h required 1 1 %h",
               rd_valid, count, rd_data, sb[0]);
    end
    exp_word = sb.pop_front();
    n_checks++;
    if (rd_data !== exp_word) begin
      n_fail++;
      $display("FAIL empty_drain: data=%h required %h", rd_data, exp_word);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      sb.push_back(8'(i));
    end
    n_checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_full: full=%0b count=%0d required 1 8", full, count);
    end
    for (int i = 0; i < 3; i++) begin
      exp_word = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        n_fail++;
        $display("FAIL fill_pop3: valid=%0b data=%h required 1 %h", rd_valid, rd_data, exp_word);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 9; i <= 11; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      sb.push_back(8'(i));
    end
    n_checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_refill: full=%0b count=%0d ovf=%0b drop=%0d required 1 8 0 0",
               full, count, overflow, drop_cnt);
    end
    while (sb.size() > 0) begin
      exp_word = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        n_fail++;
        $display("FAIL wrap_order: valid=%0b data=%h required 1 %h", rd_valid, rd_data, exp_word);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_empty: valid=%0b count=%0d data=%h required 0 0 00",
               rd_valid, count, rd_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      sb.push_back(8'(i));
    end
    drive(1'b1, 8'hE0, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_first: ovf=%0b drop=%0d required 1 1", overflow, drop_cnt);
    end
    for (int i = 1; i < 300; i++) drive(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd255 || rd_data !== sb[0] || count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_saturate: ovf=%0b drop=%0d head=%h count=%0d required 1 255 %h 8",
               overflow, drop_cnt, rd_data, count, sb[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b drop=%0d count=%0d required 0 0 8",
               overflow, drop_cnt, count);
    end
  endtask

  // Relies on the FIFO left full with head 0x01 by test_overflow.
  task automatic test_full_push_pop();
    exp_word = sb.pop_front();
    n_checks++;
    if (rd_data !== exp_word || full !== 1'b1) begin
      n_fail++;
      $display("FAIL fpp_head: data=%h full=%0b required %h 1", rd_data, full, exp_word);
    end
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    sb.push_back(8'h99);
    n_checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL fpp_status: count=%0d full=%0b ovf=%0b drop=%0d required 8 1 0 0",
               count, full, overflow, drop_cnt);
    end
    while (sb.size() > 0) begin
      exp_word = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        n_fail++;
        $display("FAIL fpp_order: valid=%0b data=%h required 1 %h", rd_valid, rd_data, exp_word);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_prefill: count=%0d required 5", count);
    end
    rst          = 1'b1;
    enable_pulse = 1'b1;
    sync_bus     = 8'h77;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    enable_pulse = 1'b0;
    sync_bus     = 8'h00;
    sb.delete();
    n_checks++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d valid=%0b data=%h required 0 0 00",
               count, rd_valid, rd_data);
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    sb.push_back(8'h3C);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== sb[0] || count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_first_push: valid=%0b data=%h count=%0d required 1 %h 1",
               rd_valid, rd_data, count, sb[0]);
    end
    void'(sb.pop_front());
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_clr_drop_collision();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      sb.push_back(8'(8'h10 + i));
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hDD, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL coll_setup: ovf=%0b drop=%0d required 1 4", overflow, drop_cnt);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL coll_result: ovf=%0b drop=%0d count=%0d required 1 1 8",
               overflow, drop_cnt, count);
    end
    while (sb.size() > 0) begin
      exp_word = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
        n_fail++;
        $display("FAIL coll_order: valid=%0b data=%h required 1 %h", rd_valid, rd_data, exp_word);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sync_bus     = 8'h00;
    enable_pulse = 1'b0;
    rd_ready     = 1'b0;
    clr_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_empty_edges();
    test_fill_wrap();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_clr_drop_collision();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
